id_exe_hazard_stage: RTL and testbench

//  ID/EXE pipeline register with integrated RAW hazard detection for the 5-stage MIPS core.

---
 rtl/id_exe_hazard_stage.sv | 131 +++++++++++++
 tb/tb_id_exe_hazard_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_hazard_stage.sv
// ID/EXE pipeline register with RAW hazard detection, freeze/flush handling and
// saturating bubble statistics for the 5-stage MIPS core.
module id_exe_hazard_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CMD_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              forwardEn,
   input  logic              freeze,
   input  logic              flush,
   input  logic [REG_W-1:0]  idSrc1,
   input  logic [REG_W-1:0]  idSrc2,
   input  logic              idUsesSrc2,
   input  logic [REG_W-1:0]  idStSrc,
   input  logic              idStOrBne,
   input  logic [REG_W-1:0]  idDst,
   input  logic              idWbEn,
   input  logic              idMemRead,
   input  logic              idMemWrite,
   input  logic [CMD_W-1:0]  idExeCmd,
   input  logic [DATA_W-1:0] idVal1,
   input  logic [DATA_W-1:0] idVal2,
   input  logic [DATA_W-1:0] idStVal,
   input  logic [DATA_W-1:0] idPc,
   input  logic [REG_W-1:0]  memDst,
   input  logic              memWbEn,
   output logic              hazardStall,
   output logic              exeValid,
   output logic [REG_W-1:0]  exeSrc1,
   output logic [REG_W-1:0]  exeSrc2,
   output logic [REG_W-1:0]  exeStSrc,
   output logic [REG_W-1:0]  exeDst,
   output logic              exeWbEn,
   output logic              exeMemRead,
   output logic              exeMemWrite,
   output logic [CMD_W-1:0]  exeCmd,
   output logic [DATA_W-1:0] exeVal1,
   output logic [DATA_W-1:0] exeVal2,
   output logic [DATA_W-1:0] exeStVal,
   output logic [DATA_W-1:0] exePc,
   output logic [CNT_W-1:0]  stallCount,
   output logic [CNT_W-1:0]  flushCount
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_ONE;
   endfunction

   // Register 0 is hardwired to zero, so a producer writing it never creates a dependency.
   function automatic logic src_hit(input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] src1,
                                    input logic [REG_W-1:0] src2,
                                    input logic             uses2,
                                    input logic [REG_W-1:0] st_src,
                                    input logic             uses_st);
      return (dst != '0) &&
             ((dst == src1) || (uses2 && dst == src2) || (uses_st && dst == st_src));
   endfunction

   logic raw_exe;
   logic raw_mem;
   logic bubble;

   always_comb begin
      raw_exe = exeWbEn && src_hit(exeDst, idSrc1, idSrc2, idUsesSrc2, idStSrc, idStOrBne);
      raw_mem = memWbEn && src_hit(memDst, idSrc1, idSrc2, idUsesSrc2, idStSrc, idStOrBne);
      // With forwarding only a load in EXE is too late; otherwise wait until the producer retires.
      hazardStall = forwardEn ? (raw_exe && exeMemRead) : (raw_exe || raw_mem);
      bubble = flush || hazardStall;
   end

   // ID -> EXE stage boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exeValid    <= 1'b0;
         exeSrc1     <= '0;
         exeSrc2     <= '0;
         exeStSrc    <= '0;
         exeDst      <= '0;
         exeWbEn     <= 1'b0;
         exeMemRead  <= 1'b0;
         exeMemWrite <= 1'b0;
         exeCmd      <= '0;
         exeVal1     <= '0;
         exeVal2     <= '0;
         exeStVal    <= '0;
         exePc       <= '0;
         stallCount  <= '0;
         flushCount  <= '0;
      end else if (!freeze) begin
         if (bubble) begin
            exeValid    <= 1'b0;
            exeSrc1     <= '0;
            exeSrc2     <= '0;
            exeStSrc    <= '0;
            exeDst      <= '0;
            exeWbEn     <= 1'b0;
            exeMemRead  <= 1'b0;
            exeMemWrite <= 1'b0;
            exeCmd      <= '0;
            exeVal1     <= '0;
            exeVal2     <= '0;
            exeStVal    <= '0;
            exePc       <= '0;
            // A flush already squashes the slot, so it is credited instead of the hazard.
            if (flush) flushCount <= sat_inc(flushCount);
            else       stallCount <= sat_inc(stallCount);
         end else begin
            exeValid    <= 1'b1;
            exeSrc1     <= idSrc1;
            exeSrc2     <= idSrc2;
            exeStSrc    <= idStSrc;
            exeDst      <= idDst;
            exeWbEn     <= idWbEn;
            exeMemRead  <= idMemRead;
            exeMemWrite <= idMemWrite;
            exeCmd      <= idExeCmd;
            exeVal1     <= idVal1;
            exeVal2     <= idVal2;
            exeStVal    <= idStVal;
            exePc       <= idPc;
         end
      end
   end

endmodule

// File: tb/tb_id_exe_hazard_stage.sv
// Self-checking bench for id_exe_hazard_stage: directed pipeline scenarios plus
// randomized traffic against a behavioural model of the EXE slot and counters.
module tb_id_exe_hazard_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        forwardEn = 1'b0, freeze = 1'b0, flush = 1'b0;
   logic [4:0]  idSrc1 = '0, idSrc2 = '0, idStSrc = '0, idDst = '0, memDst = '0;
   logic        idUsesSrc2 = 1'b0, idStOrBne = 1'b0, idWbEn = 1'b0;
   logic        idMemRead = 1'b0, idMemWrite = 1'b0, memWbEn = 1'b0;
   logic [3:0]  idExeCmd = '0;
   logic [31:0] idVal1 = '0, idVal2 = '0, idStVal = '0, idPc = '0;

   logic        hazardStall, exeValid, exeWbEn, exeMemRead, exeMemWrite;
   logic [4:0]  exeSrc1, exeSrc2, exeStSrc, exeDst;
   logic [3:0]  exeCmd;
   logic [31:0] exeVal1, exeVal2, exeStVal, exePc;
   logic [15:0] stallCount, flushCount;

   logic        s_hazardStall, s_exeValid, s_exeWbEn, s_exeMemRead, s_exeMemWrite;
   logic [4:0]  s_exeSrc1, s_exeSrc2, s_exeStSrc, s_exeDst;
   logic [3:0]  s_exeCmd;
   logic [31:0] s_exeVal1, s_exeVal2, s_exeStVal, s_exePc;
   logic [3:0]  s_stallCount, s_flushCount;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_exe_hazard_stage dut (
      .clk(clk), .rst(rst), .forwardEn(forwardEn), .freeze(freeze), .flush(flush),
      .idSrc1(idSrc1), .idSrc2(idSrc2), .idUsesSrc2(idUsesSrc2), .idStSrc(idStSrc),
      .idStOrBne(idStOrBne), .idDst(idDst), .idWbEn(idWbEn), .idMemRead(idMemRead),
      .idMemWrite(idMemWrite), .idExeCmd(idExeCmd), .idVal1(idVal1), .idVal2(idVal2),
      .idStVal(idStVal), .idPc(idPc), .memDst(memDst), .memWbEn(memWbEn),
      .hazardStall(hazardStall), .exeValid(exeValid), .exeSrc1(exeSrc1), .exeSrc2(exeSrc2),
      .exeStSrc(exeStSrc), .exeDst(exeDst), .exeWbEn(exeWbEn), .exeMemRead(exeMemRead),
      .exeMemWrite(exeMemWrite), .exeCmd(exeCmd), .exeVal1(exeVal1), .exeVal2(exeVal2),
      .exeStVal(exeStVal), .exePc(exePc), .stallCount(stallCount), .flushCount(flushCount)
   );

   // Narrow-counter copy on the same inputs so saturation is reachable in a few cycles.
   id_exe_hazard_stage #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .forwardEn(forwardEn), .freeze(freeze), .flush(flush),
      .idSrc1(idSrc1), .idSrc2(idSrc2), .idUsesSrc2(idUsesSrc2), .idStSrc(idStSrc),
      .idStOrBne(idStOrBne), .idDst(idDst), .idWbEn(idWbEn), .idMemRead(idMemRead),
      .idMemWrite(idMemWrite), .idExeCmd(idExeCmd), .idVal1(idVal1), .idVal2(idVal2),
      .idStVal(idStVal), .idPc(idPc), .memDst(memDst), .memWbEn(memWbEn),
      .hazardStall(s_hazardStall), .exeValid(s_exeValid), .exeSrc1(s_exeSrc1),
      .exeSrc2(s_exeSrc2), .exeStSrc(s_exeStSrc), .exeDst(s_exeDst), .exeWbEn(s_exeWbEn),
      .exeMemRead(s_exeMemRead), .exeMemWrite(s_exeMemWrite), .exeCmd(s_exeCmd),
      .exeVal1(s_exeVal1), .exeVal2(s_exeVal2), .exeStVal(s_exeStVal), .exePc(s_exePc),
      .stallCount(s_stallCount), .flushCount(s_flushCount)
   );

   wire [155:0] dut_vec = {exeValid, exeSrc1, exeSrc2, exeStSrc, exeDst, exeWbEn, exeMemRead,
                           exeMemWrite, exeCmd, exeVal1, exeVal2, exeStVal, exePc};
   wire [155:0] sat_vec = {s_exeValid, s_exeSrc1, s_exeSrc2, s_exeStSrc, s_exeDst, s_exeWbEn,
                           s_exeMemRead, s_exeMemWrite, s_exeCmd, s_exeVal1, s_exeVal2,
                           s_exeStVal, s_exePc};

   // Reference model: the instruction occupying EXE (zeroed when it is a bubble) and counters.
   logic [155:0] m_vec;
   logic         m_valid, m_wb, m_rd;
   logic [4:0]   m_dst;
   int           m_stall, m_flush, m_sstall, m_sflush;
   bit           auto_mem = 1'b1;

   task automatic model_reset();
      m_vec = '0; m_valid = 0; m_wb = 0; m_rd = 0; m_dst = '0;
      m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
   endtask

   function automatic bit model_hazard();
      logic [4:0] reads[$];
      bit in_exe = 0, in_mem = 0;
      reads.push_back(idSrc1);
      if (idUsesSrc2) reads.push_back(idSrc2);
      if (idStOrBne) reads.push_back(idStSrc);
      foreach (reads[i]) begin
         if (reads[i] != 0 && m_wb && reads[i] == m_dst) in_exe = 1;
         if (reads[i] != 0 && memWbEn && reads[i] == memDst) in_mem = 1;
      end
      return forwardEn ? (in_exe && m_rd) : (in_exe || in_mem);
   endfunction

   function automatic int sat(input int v, input int top);
      return (v >= top) ? top : v + 1;
   endfunction

   // One clock: model follows the edge; MEM inputs optionally inherit the old EXE occupant.
   task automatic tick();
      bit h;
      logic [4:0] pd;
      logic pw;
      h = model_hazard();
      pd = m_dst; pw = m_wb;
      @(posedge clk);
      if (!freeze) begin
         if (flush || h) begin
            m_vec = '0; m_valid = 0; m_wb = 0; m_rd = 0; m_dst = '0;
            if (flush) begin m_flush = sat(m_flush, 65535); m_sflush = sat(m_sflush, 15); end
            else begin m_stall = sat(m_stall, 65535); m_sstall = sat(m_sstall, 15); end
         end else begin
            m_vec = {1'b1, idSrc1, idSrc2, idStSrc, idDst, idWbEn, idMemRead, idMemWrite,
                     idExeCmd, idVal1, idVal2, idStVal, idPc};
            m_valid = 1; m_wb = idWbEn; m_rd = idMemRead; m_dst = idDst;
         end
      end
      #1;
      if (!freeze && auto_mem) begin memDst = pd; memWbEn = pw; end
   endtask

   task automatic set_instr(input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                            input logic [4:0] d, input logic wb, input logic rd);
      idSrc1 = s1; idSrc2 = s2; idUsesSrc2 = u2; idStSrc = '0; idStOrBne = 0;
      idDst = d; idWbEn = wb; idMemRead = rd; idMemWrite = 0;
      idExeCmd = 4'(d); idVal1 = $urandom; idVal2 = $urandom; idStVal = $urandom; idPc = $urandom;
   endtask

   task automatic set_nop();
      set_instr(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (dut_vec !== '0 || stallCount !== 16'd0 || flushCount !== 16'd0) begin
         failures++;
         $display("FAIL reset_initial exe=%h stall=%0d flush=%0d want all 0", dut_vec, stallCount, flushCount);
      end
      forwardEn = 0; memWbEn = 1; memDst = 5'd3; idSrc1 = 5'd3;
      #1;
      checks++;
      if (hazardStall !== 1'b1) begin
         failures++;
         $display("FAIL reset_comb_hazard got=%b want=1", hazardStall);
      end
      @(negedge clk); rst = 0;
      model_reset();
      // Build up stallCount=5 through a persistent MEM-stage dependency.
      auto_mem = 0;
      set_instr(5'd3, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      memWbEn = 1; memDst = 5'd3;
      repeat (5) tick();
      memWbEn = 0;
      set_instr(5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
      #1; tick();
      checks++;
      if (exeValid !== 1'b1 || stallCount !== 16'd5 || exeDst !== 5'd7) begin
         failures++;
         $display("FAIL reset_prep valid=%b stall=%0d dst=%0d want 1/5/7", exeValid, stallCount, exeDst);
      end
      #2 rst = 1;
      #1;
      checks++;
      if (dut_vec !== '0 || stallCount !== 16'd0 || flushCount !== 16'd0) begin
         failures++;
         $display("FAIL reset_async exe=%h stall=%0d flush=%0d want all 0", dut_vec, stallCount, flushCount);
      end
      model_reset();
      @(negedge clk); rst = 0;
      auto_mem = 1; memWbEn = 0; memDst = 0;
      set_nop();
      tick(); tick();
   endtask

   task automatic test_load_use_fwd();
      int base;
      forwardEn = 1; base = m_stall;
      set_instr(5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      #1;
      checks++;
      if (hazardStall !== 1'b0) begin failures++; $display("FAIL fwd_lw_issue hazard=%b want=0", hazardStall); end
      tick();
      set_instr(5'd3, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
      #1;
      checks++;
      if (hazardStall !== 1'b1) begin failures++; $display("FAIL fwd_loaduse_hazard got=%b want=1", hazardStall); end
      tick();
      checks++;
      if (exeValid !== 1'b0 || stallCount !== 16'(base + 1)) begin
         failures++;
         $display("FAIL fwd_bubble valid=%b stall=%0d want 0/%0d", exeValid, stallCount, base + 1);
      end
      #1;
      checks++;
      if (hazardStall !== 1'b0) begin failures++; $display("FAIL fwd_second_cycle hazard=%b want=0", hazardStall); end
      tick();
      checks++;
      if (exeValid !== 1'b1 || exeDst !== 5'd4 || stallCount !== 16'(base + 1)) begin
         failures++;
         $display("FAIL fwd_consumer_enters valid=%b dst=%0d stall=%0d want 1/4/%0d", exeValid, exeDst, stallCount, base + 1);
      end
   endtask

   task automatic test_no_fwd();
      int base;
      forwardEn = 0;
      set_nop(); tick(); tick();
      base = m_stall;
      set_instr(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
      set_instr(5'd3, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      repeat (4) begin #1; tick(); end
      checks++;
      if (stallCount !== 16'(base + 2) || exeDst !== 5'd5 || exeValid !== 1'b1) begin
         failures++;
         $display("FAIL nofwd_adjacent stall=%0d dst=%0d want %0d/5", stallCount, exeDst, base + 2);
      end
      set_nop(); tick(); tick();
      base = m_stall;
      set_instr(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
      set_instr(5'd7, 5'd8, 1'b1, 5'd6, 1'b1, 1'b0); tick();
      set_instr(5'd3, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      repeat (3) begin #1; tick(); end
      checks++;
      if (stallCount !== 16'(base + 1) || exeDst !== 5'd5) begin
         failures++;
         $display("FAIL nofwd_distance2 stall=%0d dst=%0d want %0d/5", stallCount, exeDst, base + 1);
      end
   endtask

   task automatic test_no_hazard_cases();
      forwardEn = 1;
      set_nop(); tick();
      set_instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); tick();
      set_instr(5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
      #1;
      checks++;
      if (hazardStall !== 1'b0) begin failures++; $display("FAIL zero_reg hazard=%b want=0", hazardStall); end
      set_instr(5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
      set_instr(5'd1, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0);
      #1;
      checks++;
      if (hazardStall !== 1'b0) begin failures++; $display("FAIL unused_src2 hazard=%b want=0", hazardStall); end
      idStSrc = 5'd3; idStOrBne = 1;
      #1;
      checks++;
      if (hazardStall !== 1'b1) begin failures++; $display("FAIL st_src_match hazard=%b want=1", hazardStall); end
      set_nop(); tick();
   endtask

   task automatic test_freeze();
      int base;
      forwardEn = 1;
      set_nop(); tick();
      set_instr(5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
      base = m_stall;
      set_instr(5'd3, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
      freeze = 1;
      repeat (3) begin
         #1;
         tick();
         checks++;
         if (exeValid !== 1'b1 || exeDst !== 5'd3 || exeMemRead !== 1'b1 || stallCount !== 16'(base)) begin
            failures++;
            $display("FAIL freeze_hold valid=%b dst=%0d rd=%b stall=%0d want 1/3/1/%0d", exeValid, exeDst, exeMemRead, stallCount, base);
         end
      end
      freeze = 0;
      #1;
      tick();
      checks++;
      if (exeValid !== 1'b0 || stallCount !== 16'(base + 1)) begin
         failures++;
         $display("FAIL freeze_release valid=%b stall=%0d want 0/%0d", exeValid, stallCount, base + 1);
      end
      tick();
      checks++;
      if (exeValid !== 1'b1 || exeDst !== 5'd4) begin
         failures++;
         $display("FAIL freeze_consumer valid=%b dst=%0d want 1/4", exeValid, exeDst);
      end
   endtask

   task automatic test_flush_sat();
      int bs, bf;
      forwardEn = 1;
      set_nop(); tick();
      set_instr(5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
      bs = m_stall; bf = m_flush;
      set_instr(5'd3, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
      flush = 1;
      #1;
      tick();
      checks++;
      if (exeValid !== 1'b0 || flushCount !== 16'(bf + 1) || stallCount !== 16'(bs)) begin
         failures++;
         $display("FAIL flush_and_stall valid=%b flush=%0d stall=%0d want 0/%0d/%0d", exeValid, flushCount, stallCount, bf + 1, bs);
      end
      repeat (20) tick();
      checks++;
      if (s_flushCount !== 4'hF || flushCount !== 16'(bf + 21)) begin
         failures++;
         $display("FAIL flush_saturate narrow=%0d wide=%0d want 15/%0d", s_flushCount, flushCount, bf + 21);
      end
      flush = 0;
      set_nop(); tick();
   endtask

   task automatic test_random();
      auto_mem = 0;
      for (int i = 0; i < 400; i++) begin
         forwardEn = 1'($urandom_range(0, 1));
         freeze = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         idSrc1 = 5'($urandom_range(0, 3)); idSrc2 = 5'($urandom_range(0, 3));
         idStSrc = 5'($urandom_range(0, 3)); idDst = 5'($urandom_range(0, 3));
         idUsesSrc2 = 1'($urandom); idStOrBne = 1'($urandom); idWbEn = 1'($urandom);
         idMemRead = 1'($urandom); idMemWrite = 1'($urandom); idExeCmd = 4'($urandom);
         idVal1 = $urandom; idVal2 = $urandom; idStVal = $urandom; idPc = $urandom;
         memDst = 5'($urandom_range(0, 3)); memWbEn = 1'($urandom);
         #1;
         checks++;
         if (hazardStall !== model_hazard()) begin
            failures++;
            $display("FAIL rand_hazard cycle=%0d got=%b want=%b", i, hazardStall, model_hazard());
         end
         tick();
         checks++;
         if (dut_vec !== m_vec || stallCount !== 16'(m_stall) || flushCount !== 16'(m_flush)) begin
            failures++;
            $display("FAIL rand_state cycle=%0d exe=%h want=%h stall=%0d/%0d flush=%0d/%0d",
                     i, dut_vec, m_vec, stallCount, m_stall, flushCount, m_flush);
         end
         checks++;
         if (sat_vec !== m_vec || s_stallCount !== 4'(m_sstall) || s_flushCount !== 4'(m_sflush)) begin
            failures++;
            $display("FAIL rand_narrow cycle=%0d stall=%0d/%0d flush=%0d/%0d",
                     i, s_stallCount, m_sstall, s_flushCount, m_sflush);
         end
      end
      freeze = 0; flush = 0; auto_mem = 1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_use_fwd();
      test_no_fwd();
      test_no_hazard_cases();
      test_freeze();
      test_flush_sat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
